// File: rtl/hazard_stall_ctrl.sv
// Decode-stage interlock for the 5-stage pipeline: a shadow scoreboard of in-flight writes
// detects RAW hazards in ID and drives stall, bubble, freeze and issue controls.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [2:0]       id_rd,
    input  logic             id_wr_en,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             freeze,
    output logic             issue,
    output logic [7:0]       busy_mask,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             exValid_q, exValid_d;
    logic [2:0]       exRd_q, exRd_d;
    logic             memValid_q, memValid_d;
    logic [2:0]       memRd_q, memRd_d;
    logic             wbValid_q, wbValid_d;
    logic [2:0]       wbRd_q, wbRd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rsMatch;
    logic       rtMatch;
    logic       hazard;
    logic       hzBubble;
    logic [7:0] slotMask;

    // No forwarding and no register-file bypass: a source stays hazardous until WB retires.
    always_comb begin
        rsMatch = (exValid_q  && (exRd_q  == id_rs)) ||
                  (memValid_q && (memRd_q == id_rs)) ||
                  (wbValid_q  && (wbRd_q  == id_rs));
        rtMatch = (exValid_q  && (exRd_q  == id_rt)) ||
                  (memValid_q && (memRd_q == id_rt)) ||
                  (wbValid_q  && (wbRd_q  == id_rt));
        hazard  = id_valid && ((id_rs_used && rsMatch) || (id_rt_used && rtMatch));
    end

    always_comb begin
        slotMask = 8'h00;
        if (exValid_q) begin
            slotMask[exRd_q] = 1'b1;
        end
        if (memValid_q) begin
            slotMask[memRd_q] = 1'b1;
        end
        if (wbValid_q) begin
            slotMask[wbRd_q] = 1'b1;
        end
    end

    // Priority: reset, memory freeze, flush, hazard, normal issue.
    always_comb begin
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        freeze      = 1'b0;
        issue       = 1'b0;
        hzBubble    = 1'b0;
        busy_mask   = 8'h00;
        stall_cnt   = '0;
        if (!rst) begin
            busy_mask = slotMask;
            stall_cnt = cnt_q;
            if (mem_stall) begin
                freeze     = 1'b1;
                stall_ifid = 1'b1;
            end else if (flush) begin
                bubble_idex = 1'b1;
            end else if (hazard) begin
                stall_ifid  = 1'b1;
                bubble_idex = 1'b1;
                hzBubble    = 1'b1;
            end else begin
                issue = id_valid;
            end
        end
    end

    always_comb begin
        exValid_d  = exValid_q;
        exRd_d     = exRd_q;
        memValid_d = memValid_q;
        memRd_d    = memRd_q;
        wbValid_d  = wbValid_q;
        wbRd_d     = wbRd_q;
        cnt_d      = cnt_q;
        if (!mem_stall) begin
            wbValid_d  = memValid_q;
            wbRd_d     = memRd_q;
            memValid_d = exValid_q;
            memRd_d    = exRd_q;
            exValid_d  = issue && id_wr_en;
            exRd_d     = id_rd;
        end
        // Only hazard bubbles are counted; the counter sticks at all-ones.
        if (hzBubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q  <= 1'b0;
            exRd_q     <= 3'd0;
            memValid_q <= 1'b0;
            memRd_q    <= 3'd0;
            wbValid_q  <= 1'b0;
            wbRd_q     <= 3'd0;
            cnt_q      <= '0;
        end else begin
            exValid_q  <= exValid_d;
            exRd_q     <= exRd_d;
            memValid_q <= memValid_d;
            memRd_q    <= memRd_d;
            wbValid_q  <= wbValid_d;
            wbRd_q     <= wbRd_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven bench for hazard_stall_ctrl: one record per cycle, outputs checked mid-cycle,
// followed by a hand-written run that drives the 4-bit stall counter into saturation.
module tb_hazard_stall_ctrl;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [2:0] rs;
        logic       rsU;
        logic [2:0] rt;
        logic       rtU;
        logic [2:0] rd;
        logic       wr;
        logic       ms;
        logic       fl;
        logic       expStall;
        logic       expBub;
        logic       expFrz;
        logic       expIss;
        logic [7:0] expMask;
        logic [3:0] expCnt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs;
    logic       id_rs_used;
    logic [2:0] id_rt;
    logic       id_rt_used;
    logic [2:0] id_rd;
    logic       id_wr_en;
    logic       mem_stall;
    logic       flush;
    logic       stall_ifid;
    logic       bubble_idex;
    logic       freeze;
    logic       issue;
    logic [7:0] busy_mask;
    logic [3:0] stall_cnt;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    hazard_stall_ctrl #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rs_used  (id_rs_used),
        .id_rt       (id_rt),
        .id_rt_used  (id_rt_used),
        .id_rd       (id_rd),
        .id_wr_en    (id_wr_en),
        .mem_stall   (mem_stall),
        .flush       (flush),
        .stall_ifid  (stall_ifid),
        .bubble_idex (bubble_idex),
        .freeze      (freeze),
        .issue       (issue),
        .busy_mask   (busy_mask),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic r, logic v, logic [2:0] rs, logic rsU, logic [2:0] rt,
                                logic rtU, logic [2:0] rd, logic wr, logic ms, logic fl,
                                logic st, logic bu, logic fr, logic is, logic [7:0] mask,
                                logic [3:0] cnt);
        vec_t x;
        x.rst = r;  x.valid = v;  x.rs = rs;  x.rsU = rsU;  x.rt = rt;  x.rtU = rtU;
        x.rd = rd;  x.wr = wr;  x.ms = ms;  x.fl = fl;
        x.expStall = st;  x.expBub = bu;  x.expFrz = fr;  x.expIss = is;
        x.expMask = mask;  x.expCnt = cnt;
        return x;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        id_valid   = v.valid;
        id_rs      = v.rs;
        id_rs_used = v.rsU;
        id_rt      = v.rt;
        id_rt_used = v.rtU;
        id_rd      = v.rd;
        id_wr_en   = v.wr;
        mem_stall  = v.ms;
        flush      = v.fl;
    endtask

    task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        cmp("stall_ifid",  idx, {7'd0, stall_ifid},  {7'd0, v.expStall});
        cmp("bubble_idex", idx, {7'd0, bubble_idex}, {7'd0, v.expBub});
        cmp("freeze",      idx, {7'd0, freeze},      {7'd0, v.expFrz});
        cmp("issue",       idx, {7'd0, issue},       {7'd0, v.expIss});
        cmp("busy_mask",   idx, busy_mask,           v.expMask);
        cmp("stall_cnt",   idx, {4'd0, stall_cnt},   {4'd0, v.expCnt});
    endtask

    // Drive inputs just after an edge, check at the falling edge, then cross the next edge.
    task automatic step(input vec_t v, input int idx);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       v;
        logic [3:0] cntModel;
        int         idx;

        applyStimulus(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00,4'd0));
        //            rst v rs u rt u rd w ms fl  st bu fr is mask  cnt
        vecs.push_back(mk(1,1,3,1,5,1,3,1,1,1, 0,0,0,0,8'h00,4'd0));   // reset with garbage
        vecs.push_back(mk(1,1,3,1,5,1,3,1,0,1, 0,0,0,0,8'h00,4'd0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00,4'd0));
        vecs.push_back(mk(0,1,0,0,0,0,3,1,0,0, 0,0,0,1,8'h00,4'd0));   // producer r3
        vecs.push_back(mk(0,1,3,1,0,0,4,1,0,0, 1,1,0,0,8'h08,4'd0));   // consumer rs=r3
        vecs.push_back(mk(0,1,3,1,0,0,4,1,0,0, 1,1,0,0,8'h08,4'd1));
        vecs.push_back(mk(0,1,3,1,0,0,4,1,0,0, 1,1,0,0,8'h08,4'd2));
        vecs.push_back(mk(0,1,3,1,0,0,4,1,0,0, 0,0,0,1,8'h00,4'd3));
        vecs.push_back(mk(0,1,0,0,0,0,5,1,0,0, 0,0,0,1,8'h10,4'd3));   // producer r5
        vecs.push_back(mk(0,1,2,1,0,0,6,0,0,0, 0,0,0,1,8'h30,4'd3));   // independent
        vecs.push_back(mk(0,1,0,0,5,1,0,0,0,0, 1,1,0,0,8'h30,4'd3));   // consumer rt=r5
        vecs.push_back(mk(0,1,0,0,5,1,0,0,0,0, 1,1,0,0,8'h20,4'd4));
        vecs.push_back(mk(0,1,0,0,5,1,0,0,0,0, 0,0,0,1,8'h00,4'd5));
        vecs.push_back(mk(0,1,0,0,0,0,5,1,0,0, 0,0,0,1,8'h00,4'd5));   // producer r5
        vecs.push_back(mk(0,1,0,0,0,0,1,0,0,0, 0,0,0,1,8'h20,4'd5));
        vecs.push_back(mk(0,1,5,0,5,0,0,0,0,0, 0,0,0,1,8'h20,4'd5));   // r5 named but unused
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h20,4'd5));
        vecs.push_back(mk(0,1,0,0,0,0,2,1,0,0, 0,0,0,1,8'h00,4'd5));   // producer r2
        vecs.push_back(mk(0,1,2,1,0,0,7,0,0,0, 1,1,0,0,8'h04,4'd5));
        vecs.push_back(mk(0,1,2,1,0,0,7,0,1,0, 1,0,1,0,8'h04,4'd6));   // freeze mid-stall
        vecs.push_back(mk(0,1,2,1,0,0,7,0,1,0, 1,0,1,0,8'h04,4'd6));
        vecs.push_back(mk(0,1,2,1,0,0,7,0,0,0, 1,1,0,0,8'h04,4'd6));
        vecs.push_back(mk(0,1,2,1,0,0,7,0,0,0, 1,1,0,0,8'h04,4'd7));
        vecs.push_back(mk(0,1,2,1,0,0,7,0,0,0, 0,0,0,1,8'h00,4'd8));
        vecs.push_back(mk(0,1,0,0,0,0,6,1,0,0, 0,0,0,1,8'h00,4'd8));   // producer r6
        vecs.push_back(mk(0,1,6,1,0,0,7,0,0,1, 0,1,0,0,8'h40,4'd8));   // flush beats hazard
        vecs.push_back(mk(0,1,6,1,0,0,7,0,0,0, 1,1,0,0,8'h40,4'd8));
        vecs.push_back(mk(0,1,6,1,0,0,7,0,0,0, 1,1,0,0,8'h40,4'd9));
        vecs.push_back(mk(0,1,6,1,0,0,7,0,0,0, 0,0,0,1,8'h00,4'd10));
        vecs.push_back(mk(0,1,0,0,0,0,1,1,1,1, 1,0,1,0,8'h00,4'd10));  // mem_stall beats flush
        vecs.push_back(mk(0,1,0,0,0,0,1,1,0,1, 0,1,0,0,8'h00,4'd10));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,8'h00,4'd10));
        vecs.push_back(mk(0,1,0,0,0,0,1,1,0,0, 0,0,0,1,8'h00,4'd10));  // producers r1, r2
        vecs.push_back(mk(0,1,0,0,0,0,2,1,0,0, 0,0,0,1,8'h02,4'd10));
        vecs.push_back(mk(0,1,1,1,2,1,0,0,0,0, 1,1,0,0,8'h06,4'd10));  // both sources busy
        vecs.push_back(mk(0,1,1,1,2,1,0,0,0,0, 1,1,0,0,8'h06,4'd11));
        vecs.push_back(mk(0,1,1,1,2,1,0,0,0,0, 1,1,0,0,8'h04,4'd12));
        vecs.push_back(mk(0,1,1,1,2,1,0,0,0,0, 0,0,0,1,8'h00,4'd13));
        vecs.push_back(mk(0,1,0,0,0,0,0,1,0,0, 0,0,0,1,8'h00,4'd13));  // producer r0
        vecs.push_back(mk(0,1,0,1,0,0,0,0,0,0, 1,1,0,0,8'h01,4'd13));
        vecs.push_back(mk(0,1,0,1,0,0,0,0,0,0, 1,1,0,0,8'h01,4'd14));
        vecs.push_back(mk(0,1,0,1,0,0,0,0,0,0, 1,1,0,0,8'h01,4'd15));
        vecs.push_back(mk(0,1,0,1,0,0,0,0,0,0, 0,0,0,1,8'h00,4'd15));
        vecs.push_back(mk(0,1,0,0,0,0,3,1,0,0, 0,0,0,1,8'h00,4'd15));  // reset mid-stall
        vecs.push_back(mk(0,1,3,1,0,0,0,0,0,0, 1,1,0,0,8'h08,4'd15));
        vecs.push_back(mk(1,1,3,1,0,0,0,0,0,0, 0,0,0,0,8'h00,4'd0));
        vecs.push_back(mk(0,1,3,1,0,0,0,0,0,0, 0,0,0,1,8'h00,4'd0));

        @(posedge clk);
        #1;
        idx = 0;
        foreach (vecs[i]) begin
            step(vecs[i], idx);
            idx++;
        end

        // Seven dependent pairs give 21 hazard bubbles; the 4-bit counter must stop at 0xF.
        cntModel = 4'd0;
        for (int p = 0; p < 7; p++) begin
            v = mk(0,1,0,0,0,0,1,1,0,0, 0,0,0,1,8'h00,cntModel);
            step(v, idx);
            idx++;
            for (int b = 0; b < 3; b++) begin
                v = mk(0,1,1,1,0,0,0,0,0,0, 1,1,0,0,8'h02,cntModel);
                step(v, idx);
                idx++;
                cntModel = (cntModel == 4'hF) ? 4'hF : cntModel + 4'd1;
            end
            v = mk(0,1,1,1,0,0,0,0,0,0, 0,0,0,1,8'h00,cntModel);
            step(v, idx);
            idx++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
